// File: rtl/sprite_motion_ctrl.sv
// Per-sprite motion controller: owns position, jump counter and map scroll for one
// tile-grid sprite, stepping on the movement tick and reacting to game state every clk.
module sprite_motion_ctrl #(
  parameter int X_W        = 5,
  parameter int Y_W        = 5,
  parameter int SHIFT_W    = 8,
  parameter int START_X    = 1,
  parameter int START_Y    = 12,
  parameter int X_MIN      = 1,
  parameter int X_MAX      = 30,
  parameter int Y_MAX      = 15,
  parameter int SCROLL_X   = 10,
  parameter int MAX_SHIFT  = 200,
  parameter int MIN_JUMP   = 2,
  parameter int MAX_JUMP   = 6,
  parameter int DEATH_JUMP = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick,
  input  logic [1:0]         game_state,
  input  logic               up,
  input  logic               forward,
  input  logic               backward,
  input  logic               umovable,
  input  logic               dmovable,
  input  logic               fmovable,
  input  logic               bmovable,
  input  logic               bounce,
  output logic [2:0]         movement,
  output logic [X_W-1:0]     pos_x,
  output logic [Y_W-1:0]     pos_y,
  output logic [SHIFT_W-1:0] shift_map,
  output logic               beginning,
  output logic               on_ground,
  output logic               fell_out
);

  typedef enum logic [2:0] {
    RISE   = 3'd0,
    FALL   = 3'd3,
    DYING  = 3'd6,
    GROUND = 3'd7
  } move_e;

  localparam int JC_MAX = (MAX_JUMP > DEATH_JUMP) ? MAX_JUMP : DEATH_JUMP;
  localparam int JC_W   = $clog2(JC_MAX + 1);

  localparam logic [1:0] GS_END   = 2'd0;
  localparam logic [1:0] GS_ING   = 2'd1;
  localparam logic [1:0] GS_START = 2'd2;

  localparam logic [X_W-1:0]     START_XL  = X_W'(START_X);
  localparam logic [Y_W-1:0]     START_YL  = Y_W'(START_Y);
  localparam logic [X_W-1:0]     X_MIN_L   = X_W'(X_MIN);
  localparam logic [X_W-1:0]     X_MAX_L   = X_W'(X_MAX);
  localparam logic [Y_W-1:0]     Y_MAX_L   = Y_W'(Y_MAX);
  localparam logic [X_W-1:0]     SCROLL_XL = X_W'(SCROLL_X);
  localparam logic [SHIFT_W-1:0] SHIFT_MAX = SHIFT_W'(MAX_SHIFT);
  localparam logic [JC_W-1:0]    MIN_JC    = JC_W'(MIN_JUMP);
  localparam logic [JC_W-1:0]    MAX_JC    = JC_W'(MAX_JUMP);
  localparam logic [JC_W-1:0]    DEATH_JC  = JC_W'(DEATH_JUMP);

  generate
    if (MIN_JUMP > MAX_JUMP) begin : g_bad_jump
      $error("sprite_motion_ctrl: MIN_JUMP must not exceed MAX_JUMP");
    end
    if ((START_Y > Y_MAX) || (Y_MAX >= (1 << Y_W))) begin : g_bad_y
      $error("sprite_motion_ctrl: need START_Y <= Y_MAX < 2**Y_W");
    end
    if (X_MAX >= (1 << X_W)) begin : g_bad_x
      $error("sprite_motion_ctrl: X_MAX must fit in X_W bits");
    end
    if (MAX_SHIFT >= (1 << SHIFT_W)) begin : g_bad_shift
      $error("sprite_motion_ctrl: MAX_SHIFT must fit in SHIFT_W bits");
    end
  endgenerate

  move_e               state, state_nxt;
  logic [JC_W-1:0]     jc, jc_nxt;
  logic [X_W-1:0]      pos_x_nxt;
  logic [Y_W-1:0]      pos_y_nxt;
  logic [SHIFT_W-1:0]  shift_nxt;
  logic                fell_nxt;
  logic                rise_stop;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= GROUND;
      pos_x     <= START_XL;
      pos_y     <= START_YL;
      shift_map <= '0;
      jc        <= '0;
      fell_out  <= 1'b0;
    end else begin
      state     <= state_nxt;
      pos_x     <= pos_x_nxt;
      pos_y     <= pos_y_nxt;
      shift_map <= shift_nxt;
      jc        <= jc_nxt;
      fell_out  <= fell_nxt;
    end
  end

  // START acts as a synchronous restart; END only forces the DYING entry, after
  // which the death hop keeps running whatever game_state says.
  always_comb begin
    state_nxt = state;
    pos_x_nxt = pos_x;
    pos_y_nxt = pos_y;
    shift_nxt = shift_map;
    jc_nxt    = jc;
    fell_nxt  = fell_out;
    rise_stop = !umovable || (jc == MAX_JC) || (pos_y == '0) || ((jc >= MIN_JC) && !up);

    if (game_state == GS_START) begin
      state_nxt = GROUND;
      pos_x_nxt = START_XL;
      pos_y_nxt = START_YL;
      shift_nxt = '0;
      jc_nxt    = '0;
      fell_nxt  = 1'b0;
    end else if ((game_state == GS_END) && (state != DYING)) begin
      state_nxt = DYING;
      jc_nxt    = '0;
    end else begin
      case (state)
        GROUND: begin
          if (up) begin
            state_nxt = RISE;
            jc_nxt    = '0;
          end else if (dmovable) begin
            state_nxt = FALL;
          end
        end
        RISE: begin
          if (tick) begin
            if (rise_stop) begin
              state_nxt = FALL;
            end else begin
              pos_y_nxt = pos_y - Y_W'(1);
              jc_nxt    = jc + JC_W'(1);
            end
          end
        end
        FALL: begin
          if (tick) begin
            if (bounce) begin
              state_nxt = RISE;
              jc_nxt    = '0;
            end else if (!dmovable) begin
              state_nxt = GROUND;
            end else if (pos_y >= Y_MAX_L) begin
              fell_nxt = 1'b1;
            end else begin
              pos_y_nxt = pos_y + Y_W'(1);
            end
          end
        end
        DYING: begin
          if (tick) begin
            if (jc < DEATH_JC) begin
              if (pos_y != '0) pos_y_nxt = pos_y - Y_W'(1);
              jc_nxt = jc + JC_W'(1);
            end else if (pos_y < Y_MAX_L) begin
              pos_y_nxt = pos_y + Y_W'(1);
            end
          end
        end
        default: state_nxt = GROUND;
      endcase

      // Past the scroll column the world moves instead of the sprite, until the map runs out.
      if (tick && (game_state == GS_ING) && (state != DYING)) begin
        if (forward) begin
          if (fmovable) begin
            if ((pos_x <= SCROLL_XL) || (shift_map == SHIFT_MAX)) begin
              if (pos_x < X_MAX_L) pos_x_nxt = pos_x + X_W'(1);
            end else if (shift_map < SHIFT_MAX) begin
              shift_nxt = shift_map + SHIFT_W'(1);
            end
          end
        end else if (backward && bmovable && (pos_x > X_MIN_L)) begin
          pos_x_nxt = pos_x - X_W'(1);
        end
      end
    end
  end

  always_comb begin
    movement  = state;
    beginning = (pos_x <= SCROLL_XL);
    on_ground = (state == GROUND);
  end

endmodule
